// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of {pc, instr} with valid/ready on both sides and a one-cycle flush.
// Optional zero-latency empty-queue bypass is compiled in when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 12,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = PC_W + INSTR_W;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ENTRY_W-1:0] head;
  logic               push;
  logic               pop;
  logic               bypass;
  logic               wr_en;
  logic               rd_en;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty && !flush && in_valid;
`else
  assign bypass = 1'b0;
`endif

  // NOTE: every output of this block is assigned a default first, so no latch can be inferred.
  always_comb begin
    out_valid = !empty || bypass;
    pop       = out_valid && out_ready;
    // A bypassed entry consumed in the same cycle never touches storage.
    wr_en     = push && !(bypass && out_ready);
    rd_en     = pop && !empty;
    pc_out    = '0;
    instr_out = '0;
    if (bypass) begin
      pc_out    = pc_in;
      instr_out = instr_in;
    end else if (!empty) begin
      {pc_out, instr_out} = head;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= {pc_in, instr_in};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: scoreboard queue of accepted entries compared against the head each cycle.
// Follows the FETCH_QUEUE_BYPASS_EN build setting so both variants can be checked with one file.
module tb_fetch_queue;

  localparam int DEPTH   = 4;
  localparam int PC_W    = 12;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic               clk;
  logic               rst_n;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    pc_in;
  logic [INSTR_W-1:0] instr_in;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    pc_out;
  logic [INSTR_W-1:0] instr_out;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;

  fetch_queue #(
    .DEPTH  (DEPTH),
    .PC_W   (PC_W),
    .INSTR_W(INSTR_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pc_in    (pc_in),
    .instr_in (instr_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pc_out   (pc_out),
    .instr_out(instr_out),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] pc);
    return {20'h00000, pc} ^ 32'h0000_0013;
  endfunction

  // One clock cycle: drive after the falling edge, check outputs mid-phase, then update the model on the rising edge.
  task automatic step(input logic f, input logic iv, input logic [PC_W-1:0] p, input logic ordy);
    int   n;
    logic byp;
    logic [INSTR_W-1:0] ins;
    entry_t hd;
    ins = instr_of(p);
    @(negedge clk);
    flush     = f;
    in_valid  = iv;
    pc_in     = p;
    instr_in  = ins;
    out_ready = ordy;
    #2;
    n   = exp_q.size();
    byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (n == 0) && !f && iv;
`endif
    check("count",     64'(count),     64'(n));
    check("empty",     64'(empty),     64'(n == 0));
    check("full",      64'(full),      64'(n == DEPTH));
    check("in_ready",  64'(in_ready),  64'(n < DEPTH));
    check("out_valid", 64'(out_valid), 64'((n > 0) || byp));
    if (byp) begin
      check("pc_bypass",    64'(pc_out),    64'(p));
      check("instr_bypass", 64'(instr_out), 64'(ins));
    end else if (n > 0) begin
      hd = exp_q[0];
      check("pc_head",    64'(pc_out),    64'(hd.pc));
      check("instr_head", 64'(instr_out), 64'(hd.instr));
    end else begin
      check("pc_empty",    64'(pc_out),    64'(0));
      check("instr_empty", 64'(instr_out), 64'(0));
    end
    @(posedge clk);
    if (f) begin
      exp_q.delete();
    end else if (!(byp && ordy)) begin
      if (ordy && n > 0) void'(exp_q.pop_front());
      if (iv && n < DEPTH) exp_q.push_back('{pc: p, instr: ins});
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    pc_in     = '0;
    instr_in  = '0;
    out_ready = 1'b0;
    #1;
    check("rst_count",     64'(count),     64'(0));
    check("rst_empty",     64'(empty),     64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // out_ready while empty: no effect
    step(1'b0, 1'b0, 12'h000, 1'b1);
    step(1'b0, 1'b0, 12'h000, 1'b0);

    // fill to DEPTH with decode stalled
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 12'(i * 4), 1'b0);
    // full: pop happens, concurrent push refused
    step(1'b0, 1'b1, 12'h010, 1'b1);
    // 0x010 accepted now
    step(1'b0, 1'b1, 12'h010, 1'b0);
    // drain completely
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b0, 12'h000, 1'b1);

    // continuous streaming, 12 entries; pointers wrap three times
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 12'(i * 4), 1'b1);
    step(1'b0, 1'b0, 12'h000, 1'b1);
    step(1'b0, 1'b0, 12'h000, 1'b0);

    // flush with concurrent push, then held flush
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 12'(12'h100 + i * 4), 1'b0);
    step(1'b1, 1'b1, 12'h200, 1'b0);
    step(1'b0, 1'b0, 12'h000, 1'b0);
    step(1'b0, 1'b1, 12'h300, 1'b0);
    step(1'b1, 1'b1, 12'h304, 1'b1);
    step(1'b1, 1'b1, 12'h308, 1'b0);
    step(1'b0, 1'b0, 12'h000, 1'b0);

    // asynchronous reset between edges with two entries queued
    step(1'b0, 1'b1, 12'h400, 1'b0);
    step(1'b0, 1'b1, 12'h404, 1'b0);
    step(1'b0, 1'b0, 12'h000, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count",     64'(count),     64'(0));
    check("arst_empty",     64'(empty),     64'(1));
    check("arst_full",      64'(full),      64'(0));
    check("arst_in_ready",  64'(in_ready),  64'(1));
    check("arst_out_valid", 64'(out_valid), 64'(0));
    check("arst_pc_out",    64'(pc_out),    64'(0));
    check("arst_instr_out", 64'(instr_out), 64'(0));
    exp_q.delete();
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b1, 12'h500, 1'b0);
    step(1'b0, 1'b0, 12'h000, 1'b1);
    step(1'b0, 1'b0, 12'h000, 1'b0);

    // empty queue, push and consume together (zero latency when bypass is built in)
    step(1'b0, 1'b1, 12'h040, 1'b1);
    step(1'b0, 1'b0, 12'h000, 1'b1);
    // empty queue, push with decode stalled
    step(1'b0, 1'b1, 12'h044, 1'b0);
    step(1'b0, 1'b0, 12'h000, 1'b1);
    step(1'b0, 1'b0, 12'h000, 1'b0);

    // mixed random traffic against the scoreboard
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
           12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
    step(1'b0, 1'b0, 12'h000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
